// File: rtl/rtr_tx.sv
// rtr_tx: four-source round-robin serial frame transmitter.
// Sends {dest[1:0], payload[3:0]} MSB first into the router.
module rtr_tx #(
    parameter int GAP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  src_valid,
    input  logic [15:0] src_data,
    output logic [3:0]  src_ack,
    output logic        out,
    output logic        rx_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    state_t      state;
    state_t      state_nx;
    logic [1:0]  last_grant;
    logic [1:0]  grant;
    logic        grant_en;
    logic [1:0]  idx;
    logic [5:0]  shreg;
    logic [2:0]  bit_cnt;
    logic [3:0]  gap_cnt;
    logic        rx_q;
    logic        busy_q;

    // round-robin pick: first valid source after last_grant, wrapping
    always_comb begin
        grant    = '0;
        grant_en = 1'b0;
        idx      = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + 2'(k);
            if (!grant_en && src_valid[idx]) begin
                grant    = idx;
                grant_en = 1'b1;
            end
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (grant_en)          state_nx = S_SHIFT;
            S_SHIFT: if (bit_cnt == 3'd5)   state_nx = S_GAP;
            S_GAP:   if (gap_cnt == GAP_LAST) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // ack is a same-cycle pulse, suppressed while reset is held
    always_comb begin
        src_ack = '0;
        if (state == S_IDLE && grant_en && !rst)
            src_ack = 4'b0001 << grant;
    end

    // shifter, counters and registered router-facing strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            last_grant <= 2'd3;
            rx_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_q   <= (state_nx == S_SHIFT);
            busy_q <= (state_nx != S_IDLE);
            unique case (state)
                S_IDLE: begin
                    if (grant_en) begin
                        shreg      <= {grant, src_data[{grant, 2'b00} +: 4]};
                        last_grant <= grant;
                        bit_cnt    <= '0;
                    end
                end
                S_SHIFT: begin
                    shreg   <= {shreg[4:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd5) gap_cnt <= '0;
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // shreg drains to zero after six shifts, so out is quiet in GAP/IDLE
    assign out      = shreg[5];
    assign rx_ready = rx_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_rtr_tx.sv
// tb_rtr_tx: random and directed stimulus for rtr_tx against
// a timeline reference model of frames, gaps and acks.
module tb_rtr_tx;

    localparam int GAP = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src_valid;
    logic [15:0] src_data;
    logic [3:0]  src_ack;
    logic        out;
    logic        rx_ready;
    logic        busy;

    always #5 clk = ~clk;

    rtr_tx #(.GAP(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ack   (src_ack),
        .out       (out),
        .rx_ready  (rx_ready),
        .busy      (busy)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    bit       pend[4];
    bit       sticky[4];
    logic [3:0] dat[4];
    bit       rnd_data;

    bit       r_out[32];
    bit       r_rx[32];
    bit       r_busy[32];
    int       free_at;
    int       last;
    logic [3:0] last_ack;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic clear_ring();
        for (int i = 0; i < 32; i++) begin
            r_out[i]  = 1'b0;
            r_rx[i]   = 1'b0;
            r_busy[i] = 1'b0;
        end
    endtask

    // one clock cycle: drive, compare against timeline, advance model
    task automatic step(input bit r);
        int g;
        int s;
        int t;
        logic [3:0] e_ack;
        logic [5:0] frame;
        logic [1:0] g2;
        @(posedge clk);
        #1;
        rst = r;
        for (int i = 0; i < 4; i++) begin
            src_valid[i]       = pend[i];
            src_data[4*i +: 4] = dat[i];
        end
        @(negedge clk);
        g = -1;
        if (!r && cyc >= free_at) begin
            for (int k = 1; k <= 4; k++) begin
                t = (last + k) % 4;
                if (g < 0 && pend[t]) g = t;
            end
        end
        e_ack = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        s = cyc % 32;
        chk("ack",  {4'b0, src_ack},  {4'b0, e_ack});
        chk("out",  {7'b0, out},      {7'b0, r_out[s]});
        chk("rx",   {7'b0, rx_ready}, {7'b0, r_rx[s]});
        chk("busy", {7'b0, busy},     {7'b0, r_busy[s]});
        r_out[s]  = 1'b0;
        r_rx[s]   = 1'b0;
        r_busy[s] = 1'b0;
        last_ack  = e_ack;
        if (r) begin
            clear_ring();
            free_at = cyc + 1;
            last    = 3;
        end else if (g >= 0) begin
            g2    = 2'(g);
            frame = {g2, dat[g]};
            for (int j = 0; j < 6; j++) begin
                t        = (cyc + 1 + j) % 32;
                r_out[t] = frame[5-j];
                r_rx[t]  = 1'b1;
            end
            for (int j = 1; j <= 6 + GAP; j++)
                r_busy[(cyc + j) % 32] = 1'b1;
            free_at = cyc + 7 + GAP;
            last    = g;
            if (!sticky[g]) pend[g] = 1'b0;
            if (rnd_data)   dat[g]  = 4'($urandom);
        end
        cyc++;
    endtask

    task automatic drop_all();
        for (int i = 0; i < 4; i++) begin
            pend[i]   = 1'b0;
            sticky[i] = 1'b0;
            dat[i]    = 4'h0;
        end
    endtask

    task automatic do_reset(input int n);
        drop_all();
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    // run until an ack is predicted, bounded
    task automatic wait_ack(input string tag, output logic [3:0] a);
        int n;
        n = 0;
        a = 4'b0;
        while (last_ack == 4'b0 && n < 60) begin
            step(1'b0);
            n++;
        end
        if (last_ack == 4'b0) begin
            errors++;
            $display("FAIL %s timeout cyc=%0d", tag, cyc);
        end
        a = last_ack;
        last_ack = 4'b0;
    endtask

    initial begin
        logic [3:0] a;
        int order[4];
        int prev;
        int seen;
        rst       = 1'b1;
        src_valid = '0;
        src_data  = '0;
        rnd_data  = 1'b0;
        last_ack  = '0;
        free_at   = 0;
        last      = 3;
        clear_ring();
        drop_all();
        @(posedge clk);

        // reset state
        do_reset(3);

        // idle with no requests
        for (int i = 0; i < 20; i++) step(1'b0);

        // source 2, payload 0xA
        pend[2] = 1'b1;
        dat[2]  = 4'hA;
        wait_ack("src2", a);
        chk("src2_ack", {4'b0, a}, 8'h04);
        for (int i = 0; i < 10; i++) step(1'b0);

        // source 1 alone, payload 0x6
        pend[1] = 1'b1;
        dat[1]  = 4'h6;
        wait_ack("src1", a);
        chk("src1_ack", {4'b0, a}, 8'h02);
        for (int i = 0; i < 10; i++) step(1'b0);

        // all four from reset: order 0,1,2,3
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            pend[i] = 1'b1;
            dat[i]  = 4'(i + 1);
        end
        prev = -1;
        for (int k = 0; k < 4; k++) begin
            wait_ack("all4", a);
            order[k] = 0;
            for (int i = 0; i < 4; i++) if (a[i]) order[k] = i;
            chk("all4_order", 8'(order[k]), 8'(k));
            if (prev >= 0) chk("all4_space", 8'(cyc - 1 - prev), 8'(7 + GAP));
            prev = cyc - 1;
        end
        for (int i = 0; i < 10; i++) step(1'b0);

        // source 3 held valid across frames
        pend[3]   = 1'b1;
        sticky[3] = 1'b1;
        dat[3]    = 4'hF;
        prev = -1;
        for (int k = 0; k < 3; k++) begin
            wait_ack("hold3", a);
            chk("hold3_ack", {4'b0, a}, 8'h08);
            if (prev >= 0) chk("hold3_space", 8'(cyc - 1 - prev), 8'(7 + GAP));
            prev = cyc - 1;
        end
        sticky[3] = 1'b0;
        wait_ack("hold3_end", a);
        for (int i = 0; i < 10; i++) step(1'b0);

        // reset during the frame, in cycle N+3
        pend[1] = 1'b1;
        dat[1]  = 4'h5;
        wait_ack("midrst", a);
        step(1'b0);
        step(1'b0);
        drop_all();
        step(1'b1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0);
            if (last_ack != 4'b0) seen++;
        end
        chk("midrst_noack", 8'(seen), 8'd0);
        last_ack = '0;
        pend[0] = 1'b1;
        dat[0]  = 4'h9;
        pend[1] = 1'b1;
        dat[1]  = 4'h3;
        wait_ack("after_rst", a);
        chk("after_rst_first", {4'b0, a}, 8'h01);
        for (int i = 0; i < 30; i++) step(1'b0);

        // randomized traffic with occasional reset
        rnd_data = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && ($urandom % 4) == 0) begin
                    pend[i] = 1'b1;
                    dat[i]  = 4'($urandom);
                end
                if (($urandom % 16) == 0) sticky[i] = ~sticky[i];
            end
            step(($urandom % 200) == 0);
        end
        drop_all();
        for (int i = 0; i < 30; i++) step(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rtr_tx.md
# rtr_tx

Four-source serial frame transmitter that feeds the serial input of the 4-output router (`rtr`). Each source presents a 4-bit payload with a valid/ack handshake. The block picks one source by round-robin arbitration and sends a 6-bit frame: a 2-bit destination equal to the source index, then the 4-bit payload. It drives the router's `in` and `rx_ready` pins directly.

## Interface
- `GAP`, default 1: number of idle cycles with `rx_ready` low after each frame. Legal range 1–15; 0 is illegal because the router acts only on a low cycle.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `src_valid`  input  4  bit i high means source i has a payload pending.
- `src_data`  input  16  packed payloads; source i uses bits [4i+3:4i].
- `src_ack`  output  4  one-hot pulse; bit i high for one cycle when source i's payload is accepted.
- `out`  output  1  serial frame bit, connects to the router's `in`.
- `rx_ready`  output  1  frame-valid strobe, connects to the router's `rx_ready`.
- `busy`  output  1  high in every cycle where the state is not IDLE.

## Operation
- The FSM has three states: IDLE, SHIFT and GAP.
- **IDLE**
  - If any `src_valid` bit is high, grant index g. Search starts at `last_grant+1` and wraps modulo 4.
  - `src_ack[g]` is high combinationally in this cycle.
  - At the clock edge: shift register loads {g[1:0], src_data[4g+3:4g]}, `last_grant` becomes g, bit counter clears to 0, state moves to SHIFT.
  - If no source is valid, stay in IDLE.
- **SHIFT**
  - `rx_ready` is 1 and `out` is `shreg[5]`.
  - Each edge shifts left by one and increments the bit counter (3 bits).
  - After the 6th bit (counter equal to 5), move to GAP and clear the gap counter.
- **GAP**
  - `rx_ready` is 0 and `out` is 0.
  - After `GAP` cycles, return to IDLE.
- Bit order on the wire: addr[1], addr[0], d[3], d[2], d[1], d[0]. After 6 shifts the router holds the address in data[5:4] and the payload in data[3:0].
- `src_ack` is zero outside IDLE. Sources must hold `src_valid` and `src_data` stable until they see ack.
- Data is sampled only in the grant cycle. Changes to a source's data after its ack do not affect the frame in flight.
- The `out` and `rx_ready` outputs are registered, so they are glitch-free toward the router.
- Reset values:
  - state = IDLE, `last_grant` = 3 (source 0 wins first), shift register = 0, counters = 0.
  - `out` = 0, `rx_ready` = 0, `busy` = 0, `src_ack` = 0.
- Reset mid-frame: `rx_ready` drops in the next cycle and the frame is abandoned, with no ack re-issued. Because the bit count is not 6, the router discards the partial frame and clears its outputs.
- Simultaneous requests: only one ack is issued per grant. Losers keep valid high and win in later rounds in round-robin order.
- A source that keeps valid high continuously gets at most one frame per round while others are requesting. When it is the only requester, it gets every frame.

## Timing
- Ack in cycle N (IDLE):
  - Frame bits appear in cycles N+1 to N+6 with `rx_ready` = 1.
  - The gap occupies cycles N+7 to N+6+GAP.
  - The earliest next ack is in cycle N+7+GAP.
- Frame period is 7+GAP cycles: 8 for the default `GAP` = 1.
- Router `tx_ready`/`dst` update on the edge that samples the first gap cycle. The full request-to-router-output latency is 8 cycles from the ack edge.
- `busy` goes high in cycle N+1 and low in cycle N+7+GAP.
- With `rst` asserted, every output is at its reset value from the cycle after the asserting edge.

## Test plan
- Source 2 valid with payload 0xA → `src_ack` = 0100 in cycle N. `out` sequence is 1,0,1,0,1,0 over N+1..N+6 with `rx_ready` high. The router then drives `dst[2]` = 0xA and `tx_ready` = 0100.
- Source 1 alone with 0x6 → bits 0,1,0,1,1,0. Router gives `dst[1]` = 6, `tx_ready` = 0010, and the other `dst` outputs are 0.
- All four sources valid from reset (payloads 1,2,3,4) with `GAP` = 1 → acks go to sources 0,1,2,3, spaced 8 cycles apart. Router `dst[i]` takes each payload in turn.
- Source 3 held valid with 0xF across two frames → two acks 8 cycles apart. Bits are 1,1,1,1,1,1, then `rx_ready` low for one cycle, then the next frame. With `GAP` = 3 the spacing is 10 cycles.
- Assert `rst` in cycle N+3 of a frame → `rx_ready` and `out` are 0 next cycle and no ack follows. The router shows no `tx_ready`. After reset releases, source 0 wins first.
- All `src_valid` low → block stays IDLE: `busy`, `rx_ready` and `src_ack` stay 0 for 20 cycles.
